// File: rtl/sync_fifo_pkg.sv
// Shared defaults, helpers and types for the single-clock FIFO.
package sync_fifo_pkg;

    localparam int DEF_DW       = 8;
    localparam int DEF_AW       = 4;
    localparam int DEF_AE_LEVEL = 4;
    localparam int DEF_FWFT     = 0;

    // Fill level / pointer type for the default geometry (one extra wrap bit).
    typedef logic [DEF_AW:0] level_t;

    // Number of address bits needed to index 'value' entries.
    function automatic int clog2_int(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

    // Number of words held by a FIFO with 'aw' address bits.
    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/sync_fifo_ram_sp.sv
// Storage array for sync_fifo_fwft: one write port, one read port with a
// registered output. The read port returns the pre-write contents when the
// same address is written in the same cycle (read-first).
import sync_fifo_pkg::*;

module fifo_ram_sp #(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam int DEPTH = depth_of(AW);

    logic [DW-1:0] mem [DEPTH];

    // Write port; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; only the output register is cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// exact fill level, optional first-word-fall-through, flush and sticky
// overflow/underflow flags. In FWFT mode the RAM output register doubles as
// the prefetch register: a separate fetch pointer runs at most one word ahead
// of the consumer pointer, and that prefetched word still counts in o_level.
import sync_fifo_pkg::*;

module sync_fifo_fwft #(
    parameter int DW       = DEF_DW,
    parameter int AW       = DEF_AW,
    parameter int AF_LEVEL = depth_of(AW) - 4,
    parameter int AE_LEVEL = DEF_AE_LEVEL,
    parameter int FWFT     = DEF_FWFT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          w_en,
    input  logic [DW-1:0] i_dat,
    output logic          w_full,
    output logic          w_almost_full,
    input  logic          r_en,
    output logic [DW-1:0] o_dat,
    output logic          r_empty,
    output logic          r_almost_empty,
    output logic [AW:0]   o_level,
    input  logic          i_flush,
    input  logic          i_clr_err,
    output logic          o_overflow,
    output logic          o_underflow
);

    localparam int          DEPTH   = depth_of(AW);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_L    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_L    = (AW+1)'(AE_LEVEL);
    localparam logic [AW:0] ONE     = (AW+1)'(1);
    localparam bit          IS_FWFT = (FWFT != 0);

    // Pointers carry one wrap bit so full and empty are distinguishable.
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic [AW:0] fptr;
    logic        head_valid;

    logic [AW:0] wptr_nx;
    logic [AW:0] rptr_nx;
    logic [AW:0] fptr_nx;
    logic [AW:0] level_nx;
    logic        head_valid_nx;
    logic        empty_nx;
    logic        ovf_nx;
    logic        unf_nx;

    logic        rd_acc;
    logic        wr_acc;
    logic        fetch;
    logic        ovf_set;
    logic        unf_set;

    logic          ram_rd_en;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;

    // Accept decisions, next pointer/level/flag values and RAM read control.
    always_comb begin
        rd_acc  = r_en && !r_empty && !i_flush;
        wr_acc  = w_en && (!w_full || rd_acc) && !i_flush;
        ovf_set = w_en && w_full && !rd_acc && !i_flush;
        unf_set = r_en && r_empty && !i_flush;

        // Prefetch whenever the head slot is free or being consumed and the
        // RAM holds a word that has not yet been fetched.
        fetch = IS_FWFT && !i_flush && (wptr != fptr) && (!head_valid || rd_acc);

        wptr_nx       = wptr;
        rptr_nx       = rptr;
        fptr_nx       = fptr;
        head_valid_nx = head_valid;

        if (i_flush) begin
            wptr_nx       = '0;
            rptr_nx       = '0;
            fptr_nx       = '0;
            head_valid_nx = 1'b0;
        end else begin
            if (wr_acc) begin
                wptr_nx = wptr + ONE;
            end
            if (rd_acc) begin
                rptr_nx = rptr + ONE;
            end
            if (fetch) begin
                fptr_nx       = fptr + ONE;
                head_valid_nx = 1'b1;
            end else if (rd_acc) begin
                head_valid_nx = 1'b0;
            end
        end

        level_nx = wptr_nx - rptr_nx;

        if (IS_FWFT) begin
            empty_nx = !head_valid_nx;
        end else begin
            empty_nx = (level_nx == '0);
        end

        // A set in the same cycle as a clear leaves the flag set.
        ovf_nx = o_overflow;
        if (ovf_set) begin
            ovf_nx = 1'b1;
        end else if (i_clr_err) begin
            ovf_nx = 1'b0;
        end

        unf_nx = o_underflow;
        if (unf_set) begin
            unf_nx = 1'b1;
        end else if (i_clr_err) begin
            unf_nx = 1'b0;
        end

        if (IS_FWFT) begin
            ram_rd_en   = fetch;
            ram_rd_addr = fptr[AW-1:0];
        end else begin
            ram_rd_en   = rd_acc;
            ram_rd_addr = rptr[AW-1:0];
        end
    end

    // Pointer, prefetch and registered status state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr           <= '0;
            rptr           <= '0;
            fptr           <= '0;
            head_valid     <= 1'b0;
            o_level        <= '0;
            r_empty        <= 1'b1;
            w_full         <= 1'b0;
            r_almost_empty <= 1'b1;
            w_almost_full  <= 1'b0;
            o_overflow     <= 1'b0;
            o_underflow    <= 1'b0;
        end else begin
            wptr           <= wptr_nx;
            rptr           <= rptr_nx;
            fptr           <= fptr_nx;
            head_valid     <= head_valid_nx;
            o_level        <= level_nx;
            r_empty        <= empty_nx;
            w_full         <= (level_nx == DEPTH_L);
            r_almost_empty <= (level_nx <= AE_L);
            w_almost_full  <= (level_nx >= AF_L);
            o_overflow     <= ovf_nx;
            o_underflow    <= unf_nx;
        end
    end

    fifo_ram_sp #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wptr[AW-1:0]),
        .wr_data (i_dat),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

    assign o_dat = ram_rd_data;

endmodule
